// File: rtl/fb_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_ctrl
// Purpose  : Streams renderer pixels into the back frame buffer, column-major,
//            restarting each pass on a ping-pong buffer swap.
// Revision : 1.0  initial release
// ============================================================================
module fb_write_ctrl #(
    parameter int          XMAX      = 240,
    parameter int          YMAX      = 264,
    parameter logic [15:0] PARK_ADDR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        buf_sel,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic [7:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] addr_write,
    output logic [7:0]  data_write,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [7:0] X_LAST = 8'(XMAX - 1);
    localparam logic [8:0] Y_LAST = 9'(YMAX - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [15:0] cnt_q, cnt_d;
    logic        buf_sel_q;
    logic [15:0] addr_write_q, addr_write_d;
    logic [7:0]  data_write_q, data_write_d;
    logic        frame_done_q, frame_done_d;
    logic        overrun_q, overrun_d;

    logic        swap;
    logic        accept;
    logic        last_pix;

    assign swap     = buf_sel ^ buf_sel_q;
    assign accept   = pix_valid && (state_q == S_FILL);
    assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        cnt_d        = cnt_q;
        addr_write_d = PARK_ADDR;
        data_write_d = data_write_q;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;

        // The write is captured from the pre-update counter, so a pixel
        // accepted on a swap cycle still lands at its old address.
        if (accept) begin
            addr_write_d = cnt_q;
            data_write_d = pix_data;
            cnt_d        = cnt_q + 16'd1;
            if (y_q == Y_LAST) begin
                y_d = 9'd0;
                x_d = x_q + 8'd1;
            end else begin
                y_d = y_q + 9'd1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (swap) begin
                    state_d = S_FILL;
                    x_d     = 8'd0;
                    y_d     = 9'd0;
                    cnt_d   = 16'd0;
                end
            end
            S_FILL: begin
                if (accept && last_pix) begin
                    frame_done_d = 1'b1;
                    state_d      = swap ? S_FILL : S_DONE;
                    x_d          = 8'd0;
                    y_d          = 9'd0;
                    cnt_d        = 16'd0;
                end else if (swap) begin
                    overrun_d = 1'b1;
                    x_d       = 8'd0;
                    y_d       = 9'd0;
                    cnt_d     = 16'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x_q          <= 8'd0;
            y_q          <= 9'd0;
            cnt_q        <= 16'd0;
            buf_sel_q    <= 1'b0;
            addr_write_q <= PARK_ADDR;
            data_write_q <= 8'd0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            buf_sel_q    <= buf_sel;
            addr_write_q <= addr_write_d;
            data_write_q <= data_write_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign pix_ready  = (state_q == S_FILL);
    assign busy       = (state_q == S_FILL);
    assign pix_x      = pix_ready ? x_q : 8'd0;
    assign pix_y      = pix_ready ? y_q : 9'd0;
    assign addr_write = addr_write_q;
    assign data_write = data_write_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_write_ctrl
// Purpose  : Self-checking bench: full-size instance for long-run behaviour,
//            3x4 instance for a hand-computed vector table.
// Revision : 1.0  initial release
// ============================================================================
module tb_fb_write_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Full-size instance
    logic        rst_m, m_sel, m_val;
    logic [7:0]  m_data;
    logic        m_rdy, m_busy, m_fd, m_ov;
    logic [7:0]  m_x, m_wd;
    logic [8:0]  m_y;
    logic [15:0] m_addr;

    fb_write_ctrl dut_m (
        .clk(clk), .rst(rst_m), .buf_sel(m_sel), .pix_valid(m_val), .pix_data(m_data),
        .pix_ready(m_rdy), .pix_x(m_x), .pix_y(m_y), .addr_write(m_addr),
        .data_write(m_wd), .busy(m_busy), .frame_done(m_fd), .overrun(m_ov)
    );

    // Small instance: 3 columns x 4 rows, park at 0x00AA
    logic        rst_s, s_sel, s_val;
    logic [7:0]  s_data;
    logic        s_rdy, s_busy, s_fd, s_ov;
    logic [7:0]  s_x, s_wd;
    logic [8:0]  s_y;
    logic [15:0] s_addr;

    fb_write_ctrl #(.XMAX(3), .YMAX(4), .PARK_ADDR(16'h00AA)) dut_s (
        .clk(clk), .rst(rst_s), .buf_sel(s_sel), .pix_valid(s_val), .pix_data(s_data),
        .pix_ready(s_rdy), .pix_x(s_x), .pix_y(s_y), .addr_write(s_addr),
        .data_write(s_wd), .busy(s_busy), .frame_done(s_fd), .overrun(s_ov)
    );

    logic [44:0] m_pk, s_pk;
    assign m_pk = {m_rdy, m_x, m_y, m_addr, m_wd, m_busy, m_fd, m_ov};
    assign s_pk = {s_rdy, s_x, s_y, s_addr, s_wd, s_busy, s_fd, s_ov};

    typedef struct {
        logic        sel;
        logic        val;
        logic [7:0]  d;
        logic [44:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // {ready, x, y, addr, wdata, busy, frame_done, overrun}
    function automatic logic [44:0] ex(input logic rdy, input logic [7:0] x,
                                       input logic [8:0] y, input logic [15:0] a,
                                       input logic [7:0] wd, input logic bz,
                                       input logic fd, input logic ov);
        return {rdy, x, y, a, wd, bz, fd, ov};
    endfunction

    task automatic chk(input string nm, input logic [44:0] act, input logic [44:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic sel, input logic val, input logic [7:0] d,
                        input logic [44:0] e);
        vec_t v;
        v.sel = sel; v.val = val; v.d = d; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int errs;
        int fd_n;

        rst_m = 1'b0; m_sel = 1'b0; m_val = 1'b0; m_data = 8'h00;
        rst_s = 1'b0; s_sel = 1'b0; s_val = 1'b0; s_data = 8'h00;

        // Small-instance vector table: inputs applied, then outputs after the edge
        addv(0, 1, 8'h11, ex(0, 0, 0, 16'h00AA, 8'h00, 0, 0, 0));
        addv(1, 1, 8'h12, ex(1, 0, 0, 16'h00AA, 8'h00, 1, 0, 0));
        addv(1, 1, 8'h20, ex(1, 0, 1, 16'd0,    8'h20, 1, 0, 0));
        addv(1, 0, 8'h21, ex(1, 0, 1, 16'h00AA, 8'h20, 1, 0, 0));
        addv(1, 1, 8'h22, ex(1, 0, 2, 16'd1,    8'h22, 1, 0, 0));
        addv(1, 1, 8'h23, ex(1, 0, 3, 16'd2,    8'h23, 1, 0, 0));
        addv(1, 1, 8'h24, ex(1, 1, 0, 16'd3,    8'h24, 1, 0, 0));
        addv(0, 1, 8'h25, ex(1, 0, 0, 16'd4,    8'h25, 1, 0, 1));
        for (int k = 0; k < 11; k++)
            addv(0, 1, 8'(48 + k), ex(1, 8'((k + 1) / 4), 9'((k + 1) % 4), 16'(k), 8'(48 + k), 1, 0, 0));
        addv(0, 1, 8'h3B, ex(0, 0, 0, 16'd11,   8'h3B, 0, 1, 0));
        addv(0, 1, 8'h50, ex(0, 0, 0, 16'h00AA, 8'h3B, 0, 0, 0));
        addv(1, 1, 8'h51, ex(1, 0, 0, 16'h00AA, 8'h3B, 1, 0, 0));
        for (int k = 0; k < 11; k++)
            addv(1, 1, 8'(96 + k), ex(1, 8'((k + 1) / 4), 9'((k + 1) % 4), 16'(k), 8'(96 + k), 1, 0, 0));
        addv(0, 1, 8'h6B, ex(1, 0, 0, 16'd11,   8'h6B, 1, 1, 0));
        addv(0, 0, 8'h6C, ex(1, 0, 0, 16'h00AA, 8'h6B, 1, 0, 0));
        addv(0, 1, 8'h70, ex(1, 0, 1, 16'd0,    8'h70, 1, 0, 0));

        #2;
        rst_m = 1'b1; rst_s = 1'b1;
        #1;
        chk("reset_m", m_pk, ex(0, 0, 0, 16'hFFFF, 8'h00, 0, 0, 0));
        chk("reset_s", s_pk, ex(0, 0, 0, 16'h00AA, 8'h00, 0, 0, 0));
        step(); step();
        rst_m = 1'b0; rst_s = 1'b0;

        foreach (vq[i]) begin
            s_sel = vq[i].sel; s_val = vq[i].val; s_data = vq[i].d;
            step();
            chk($sformatf("vec%0d", i), s_pk, vq[i].exp);
        end

        // Enter FILL, then valid 1,0,1
        m_sel = 1'b1; m_val = 1'b0;
        step();
        chk("m_enter_fill", m_pk, ex(1, 0, 0, 16'hFFFF, 8'h00, 1, 0, 0));
        m_val = 1'b1; m_data = 8'hA0;
        step();
        chk("m_acc0", m_pk, ex(1, 0, 1, 16'd0, 8'hA0, 1, 0, 0));
        m_val = 1'b0;
        step();
        chk("m_stall", m_pk, ex(1, 0, 1, 16'hFFFF, 8'hA0, 1, 0, 0));
        m_val = 1'b1; m_data = 8'hA1;
        step();
        chk("m_acc1", m_pk, ex(1, 0, 2, 16'd1, 8'hA1, 1, 0, 0));

        // Run to 999 acceptances, checking the column wrap on the way
        errs = 0;
        for (int k = 2; k < 999; k++) begin
            m_data = 8'(k);
            step();
            if (m_addr !== 16'(k) || m_wd !== 8'(k)) errs++;
            if (k == 263) chk("m_ywrap", m_pk, ex(1, 1, 0, 16'd263, 8'h07, 1, 0, 0));
            if (k == 264) chk("m_addr264", m_pk, ex(1, 1, 1, 16'd264, 8'h08, 1, 0, 0));
        end
        chk("m_run_writes", 45'(errs), 45'd0);

        // Swap on the 1000th acceptance
        m_sel = 1'b0; m_data = 8'hE7;
        step();
        chk("m_overrun", m_pk, ex(1, 0, 0, 16'd999, 8'hE7, 1, 0, 1));
        m_data = 8'h5A;
        step();
        chk("m_restart", m_pk, ex(1, 0, 1, 16'd0, 8'h5A, 1, 0, 0));

        // Asynchronous reset mid-pass
        #3 rst_m = 1'b1;
        #1;
        chk("m_async_rst", m_pk, ex(0, 0, 0, 16'hFFFF, 8'h00, 0, 0, 0));
        step();
        rst_m = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("m_post_rst_idle", m_pk, ex(0, 0, 0, 16'hFFFF, 8'h00, 0, 0, 0));
        end

        // Full frame with data = address[7:0]
        m_sel = 1'b1; m_data = 8'h00;
        step();
        chk("m_frame_start", m_pk, ex(1, 0, 0, 16'hFFFF, 8'h00, 1, 0, 0));
        errs = 0;
        fd_n = 0;
        for (int k = 0; k < 63360; k++) begin
            m_data = 8'(k);
            step();
            if (m_addr !== 16'(k) || m_wd !== 8'(k)) errs++;
            if (m_fd === 1'b1) fd_n++;
            if (k == 63359)
                chk("m_frame_last", m_pk, ex(0, 0, 0, 16'd63359, 8'h7F, 0, 1, 0));
        end
        chk("m_frame_writes", 45'(errs), 45'd0);
        chk("m_frame_done_count", 45'(fd_n), 45'd1);
        step();
        chk("m_after_done", m_pk, ex(0, 0, 0, 16'hFFFF, 8'h7F, 0, 0, 0));

        // buf_sel already high when reset releases
        #3 rst_m = 1'b1;
        step();
        rst_m = 1'b0;
        step();
        chk("m_sel_high_release", m_pk, ex(1, 0, 0, 16'hFFFF, 8'h00, 1, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fb_write_ctrl.md
FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

Interface
REQ-001 Parameter XMAX, default 240: frame-buffer columns per frame (xpos range 0..XMAX-1).
REQ-002 Parameter YMAX, default 264: frame-buffer rows per column (ypos range 0..YMAX-1); buffer address = xpos*YMAX + ypos.
REQ-003 Parameter PARK_ADDR, default 16'hFFFF: scratch address driven whenever no pixel is being written.
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 buf_sel  in  1  ping-pong write-buffer select from frame buffer; any change of level marks a buffer swap.
REQ-007 pix_valid  in  8-bit pixel presented by renderer this cycle (1 bit).
REQ-008 pix_data  in  8  renderer pixel colour.
REQ-009 pix_ready  out  1  controller accepts a pixel this cycle.
REQ-010 pix_x  out  8  xpos of the pixel currently requested.
REQ-011 pix_y  out  9  ypos of the pixel currently requested.
REQ-012 addr_write  out  16  frame-buffer write address (back buffer).
REQ-013 data_write  out  8  frame-buffer write data.
REQ-014 busy  out  1  high while in FILL.
REQ-015 frame_done  out  1  one-cycle pulse when the last pixel of a pass has been written.
REQ-016 overrun  out  1  one-cycle pulse when a swap arrives before a pass completes.

Function
REQ-017 Controller SHALL hold buf_sel_q, a one-cycle registered copy of buf_sel; swap = (buf_sel != buf_sel_q).
REQ-018 States SHALL be IDLE, FILL, DONE; encoding free.
REQ-019 IDLE: pix_ready=0; on swap go to FILL with x=0, y=0, addr counter=0.
REQ-020 FILL: pix_ready=1; pix_x=x, pix_y=y, driven combinationally from counters.
REQ-021 Handshake: a pixel is accepted on a cycle with pix_valid & pix_ready; no acceptance otherwise, counters hold.
REQ-022 On acceptance, next cycle addr_write = addr counter value at acceptance and data_write = pix_data (latency 1 cycle, registered).
REQ-023 On any cycle with no acceptance, next cycle addr_write = PARK_ADDR; data_write holds its previous value.
REQ-024 Counter order: y increments per acceptance; at y=YMAX-1 y wraps to 0 and x increments; addr counter increments by 1 per acceptance (16-bit, never exceeds XMAX*YMAX-1 = 63359).
REQ-025 Acceptance at x=XMAX-1, y=YMAX-1 SHALL move to DONE; frame_done pulses high on the cycle that pixel's write appears on addr_write.
REQ-026 DONE: pix_ready=0, addr_write=PARK_ADDR; on swap go to FILL with counters cleared.
REQ-027 Swap while in FILL: overrun pulses next cycle, counters cleared, state stays FILL; a pixel accepted on the swap cycle SHALL still be written at its old address.
REQ-028 Swap coincident with last-pixel acceptance: treat as completion (frame_done) followed by restart into FILL; no overrun.
REQ-029 busy SHALL equal (state==FILL).
REQ-030 pix_x/pix_y SHALL read 0 outside FILL.

Reset
REQ-031 On rst high, immediately: state=IDLE, x=0, y=0, addr counter=0, buf_sel_q=0, addr_write=PARK_ADDR, data_write=0, frame_done=0, overrun=0.
REQ-032 Reset asserted mid-FILL SHALL abandon the pass with no further writes; first action after release is waiting in IDLE for a swap.
REQ-033 If buf_sel=1 at reset release, first clock SHALL register a swap (buf_sel_q=0) and enter FILL.

Verification
REQ-034 Reset, buf_sel 0->1, pix_valid held 1 with pix_data=address[7:0] -> 63360 consecutive writes at addr 0..63359, frame_done one pulse one cycle after final acceptance, then addr_write=16'hFFFF.
REQ-035 In FILL, pix_valid toggled 1,0,1 -> writes at addr 0 then 16'hFFFF then addr 1; pix_y advances 0->1 only after acceptance.
REQ-036 Acceptance at x=0,y=263 -> next pix_x=1, pix_y=0, next address 264.
REQ-037 Swap after 1000 acceptances -> overrun pulse, pix_x=pix_y=0, next write at addr 0; write 999 still issued.
REQ-038 Swap on same cycle as acceptance of x=239,y=263 -> write to 63359, frame_done pulse, overrun stays 0, busy stays 1, next request x=0,y=0.
REQ-039 rst pulsed mid-FILL -> outputs at reset values asynchronously, no writes until next buf_sel change.
